uart_cmd_rx: RTL and testbench

//  Serial command receiver, directly upstream of the main controller.

---
 rtl/uart_cmd_rx.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_rx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver feeding the command decoder.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err strobe.
module uart_cmd_rx #(
    parameter int CLK_PER_BIT = 100,
    parameter int CTR_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd3;
`endif
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BREAK = 3'd5;

    localparam logic [CTR_W-1:0] HALF_M1 = CTR_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_W-1:0] FULL_M1 = CTR_W'(CLK_PER_BIT - 1);
    localparam logic [CTR_W-1:0] ONE     = CTR_W'(1);

    logic             sync1;
    logic             sync2;
    logic             rxs;
    logic [2:0]       state;
    logic [CTR_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;
    assign par_bad    = (^shreg) ^ par_bit;
    assign parity_err = par_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign rxs  = sync2;
    assign busy = (state != S_IDLE);

    // Synchroniser, bit timer, frame FSM and output strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state       <= S_IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            new_rx_data <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync1       <= rx;
            sync2       <= sync1;
            new_rx_data <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    if (timer == HALF_M1) begin
                        timer <= '0;
                        state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        timer <= timer + ONE;
                    end
                end
                S_DATA: begin
                    if (timer == FULL_M1) begin
                        timer   <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PAR;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        timer <= timer + ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PAR: begin
                    if (timer == FULL_M1) begin
                        timer   <= '0;
                        par_bit <= rxs;
                        state   <= S_STOP;
                    end else begin
                        timer <= timer + ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (timer == FULL_M1) begin
                        timer <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                            par_err_q <= 1'b1;
`endif
                            state     <= S_IDLE;
                        end else begin
                            rx_data     <= shreg;
                            new_rx_data <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + ONE;
                    end
                end
                S_BREAK: begin
                    timer <= '0;
                    if (rxs) state <= S_IDLE;
                end
                default: begin
                    timer <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed bench for uart_cmd_rx at 16 clocks/bit.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_cmd_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + PB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int n_new = 0;
    int n_fe = 0;
    int n_pe = 0;
    int overlap = 0;
    int stuck = 0;
    int pulse_cyc[$];
    logic [7:0] pulse_dat[$];
    logic prev_strobe = 1'b0;

    uart_cmd_rx #(.CLK_PER_BIT(CPB), .CTR_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .new_rx_data(new_rx_data),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts pulses, records timing and data
    always @(posedge clk) begin
        logic any;
        cyc = cyc + 1;
        #1;
        if (new_rx_data) begin
            n_new = n_new + 1;
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(rx_data);
        end
        if (frame_err) n_fe = n_fe + 1;
        if (parity_err) n_pe = n_pe + 1;
        if (32'(new_rx_data) + 32'(frame_err) + 32'(parity_err) > 1)
            overlap = overlap + 1;
        any = new_rx_data | frame_err | parity_err;
        if (any && prev_strobe && !rst) stuck = stuck + 1;
        prev_strobe = any;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stp, input logic par);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PB == 1) drive_bit(par);
        drive_bit(stp);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data got %h want 00", rx_data);
        end
        checks++;
        if ({new_rx_data, frame_err, parity_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b want 000",
                     {new_rx_data, frame_err, parity_err});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        rst = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_single;
        int n0;
        int fe0;
        n0 = n_new;
        fe0 = n_fe;
        pulse_cyc.delete();
        pulse_dat.delete();
        send_frame(8'h64, 1'b1, ^8'h64);
        idle_bits(1);
        checks++;
        if (n_new - n0 != 1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", n_new - n0);
        end else begin
            checks++;
            if (pulse_dat[0] !== 8'h64) begin
                errors++;
                $display("FAIL single_data got %h want 64", pulse_dat[0]);
            end
            checks++;
            if (pulse_cyc[0] - start_cyc != LAT) begin
                errors++;
                $display("FAIL single_latency got %0d want %0d",
                         pulse_cyc[0] - start_cyc, LAT);
            end
        end
        checks++;
        if (n_fe != fe0) begin
            errors++;
            $display("FAIL single_ferr got %0d want 0", n_fe - fe0);
        end
    endtask

    task automatic test_back_to_back;
        pulse_cyc.delete();
        pulse_dat.delete();
        send_frame(8'h64, 1'b1, ^8'h64);
        send_frame(8'h68, 1'b1, ^8'h68);
        idle_bits(1);
        checks++;
        if (pulse_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d want 2", pulse_cyc.size());
        end else begin
            checks++;
            if (pulse_cyc[1] - pulse_cyc[0] != 10 * CPB + 10 * PB * CPB / 10 * 1) begin
                errors++;
                $display("FAIL b2b_gap got %0d want %0d",
                         pulse_cyc[1] - pulse_cyc[0], 10 * CPB + PB * CPB);
            end
            checks++;
            if ({pulse_dat[0], pulse_dat[1]} !== 16'h6468) begin
                errors++;
                $display("FAIL b2b_data got %h %h want 64 68",
                         pulse_dat[0], pulse_dat[1]);
            end
        end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = n_new;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (CPB + 4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_new != n0 || n_fe != 0) begin
            errors++;
            $display("FAIL glitch got busy=%b new=%0d fe=%0d want 0 0 0",
                     busy, n_new - n0, n_fe);
        end
        pulse_dat.delete();
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle_bits(1);
        checks++;
        if (pulse_dat.size() != 1 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL glitch_next got n=%0d data=%h want 1 a5",
                     pulse_dat.size(), rx_data);
        end
    endtask

    task automatic test_break;
        int n0;
        int fe0;
        n0 = n_new;
        fe0 = n_fe;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        idle_bits(2);
        checks++;
        if (n_fe - fe0 != 1) begin
            errors++;
            $display("FAIL break_ferr got %0d want 1", n_fe - fe0);
        end
        checks++;
        if (n_new != n0 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL break_data got new=%0d data=%h want 0 a5",
                     n_new - n0, rx_data);
        end
        send_frame(8'h01, 1'b1, ^8'h01);
        idle_bits(1);
        checks++;
        if (n_new - n0 != 1 || rx_data !== 8'h01) begin
            errors++;
            $display("FAIL break_next got n=%0d data=%h want 1 01",
                     n_new - n0, rx_data);
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        int fe0;
        n0 = n_new;
        fe0 = n_fe;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_data !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got data=%h busy=%b want 00 0",
                     rx_data, busy);
        end
        checks++;
        if ({new_rx_data, frame_err, parity_err} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_strobes got %b want 000",
                     {new_rx_data, frame_err, parity_err});
        end
        rst = 1'b0;
        idle_bits(2);
        checks++;
        if (n_new != n0 || n_fe != fe0) begin
            errors++;
            $display("FAIL midrst_quiet got new=%0d fe=%0d want 0 0",
                     n_new - n0, n_fe - fe0);
        end
        send_frame(8'hFF, 1'b1, ^8'hFF);
        idle_bits(1);
        checks++;
        if (n_new - n0 != 1 || rx_data !== 8'hFF) begin
            errors++;
            $display("FAIL midrst_next got n=%0d data=%h want 1 ff",
                     n_new - n0, rx_data);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int n0;
        int pe0;
        n0 = n_new;
        pe0 = n_pe;
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(1);
        checks++;
        if (n_pe - pe0 != 1 || n_new != n0) begin
            errors++;
            $display("FAIL parity_bad got pe=%0d new=%0d want 1 0",
                     n_pe - pe0, n_new - n0);
        end
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(1);
        checks++;
        if (n_new - n0 != 1 || rx_data !== 8'h07 || n_pe - pe0 != 1) begin
            errors++;
            $display("FAIL parity_good got new=%0d data=%h pe=%0d want 1 07 1",
                     n_new - n0, rx_data, n_pe - pe0);
        end
    endtask
`else
    task automatic test_parity;
        checks++;
        if (n_pe != 0) begin
            errors++;
            $display("FAIL parity_tied got %0d want 0", n_pe);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
        test_parity();
        checks++;
        if (overlap != 0 || stuck != 0) begin
            errors++;
            $display("FAIL strobe_shape got overlap=%0d stuck=%0d want 0 0",
                     overlap, stuck);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
